// File: rtl/interval_pkg.sv
// Shared types and defaults for the interval meter and its companion generator.
package interval_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } meter_state_t;

  localparam int CLKS_PER_MS_DEFAULT = 100_000;
  localparam int MS_CNT_W            = 16;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by one history flop; flags both rising and falling edges.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level      = s3;
  assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/interval_meter.sv
// Measures whole milliseconds between consecutive toggles of an asynchronous input,
// with a saturating ms counter, one-cycle valid strobe and a stall/timeout flag.
module interval_meter
  import interval_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
  parameter int CNT_W       = MS_CNT_W,
  parameter int TIMEOUT_MS  = 10_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_ms,
  output logic             valid,
  output logic             timeout,
  output logic             level,
  output meter_state_t     state_dbg
);

  localparam int              CYC_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam longint          CNT_MAX_L = (longint'(1) << CNT_W) - 1;
  // A timeout at or beyond the saturation value could never be told apart from
  // a saturated count, so it is treated as disabled and reports the saturated value.
  localparam bit              TIMEOUT_EN  = (TIMEOUT_MS != 0) && (longint'(TIMEOUT_MS) < CNT_MAX_L);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_MS);

  logic             sig_edge;
  logic             sig_level;

  logic [CYC_W-1:0] cyc;
  logic [CNT_W-1:0] ms_cnt;
  logic             tick;
  logic [CNT_W-1:0] ms_inc;
  logic [CNT_W-1:0] latched;
  logic             stall_hit;

  meter_state_t     state;
  meter_state_t     state_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d;
  logic             timeout_d;

  sync_edge u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (sig_in),
    .level      (sig_level),
    .edge_pulse (sig_edge)
  );

  assign tick      = (cyc == CYC_LAST);
  assign ms_inc    = (ms_cnt == CNT_MAX) ? ms_cnt : ms_cnt + CNT_W'(1);
  // An edge landing on a tick still counts the millisecond that just completed.
  assign latched   = tick ? ms_inc : ms_cnt;
  assign stall_hit = TIMEOUT_EN && (ms_cnt == TIMEOUT_VAL);

  // Prescaler and ms counter; an edge re-aligns the millisecond phase to itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc    <= '0;
      ms_cnt <= '0;
    end else if (sig_edge) begin
      cyc    <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      cyc    <= '0;
      ms_cnt <= ms_inc;
    end else begin
      cyc    <= cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      period_ms <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      period_ms <= period_d;
      valid     <= valid_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    period_d  = period_ms;
    valid_d   = 1'b0;
    timeout_d = timeout;
    unique case (state)
      IDLE: begin
        if (sig_edge) state_d = MEASURE;
      end
      MEASURE: begin
        if (sig_edge) begin
          period_d = latched;
          valid_d  = 1'b1;
        end else if (stall_hit) begin
          state_d   = STALL;
          timeout_d = 1'b1;
        end
      end
      STALL: begin
        // The interval spanning the stall is meaningless, so no measurement here.
        if (sig_edge) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
      end
    endcase
  end

  assign level     = sig_level;
  assign state_dbg = state;

endmodule

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter: a main instance (16-bit, 50 ms timeout) and a
// saturation instance (4-bit, no timeout) share one input and one interval model.
module tb_interval_meter;
  import interval_pkg::*;

  localparam int CLKS  = 10;
  localparam int TMO   = 50;
  localparam int SAT_W = 4;

  // clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sig_in  = 1'b0;

  always #5 clk = ~clk;

  logic [15:0]      period_main;
  logic             valid_main;
  logic             timeout_main;
  logic             level_main;
  meter_state_t     state_main;

  logic [SAT_W-1:0] period_sat;
  logic             valid_sat;
  logic             timeout_sat;
  logic             level_sat;
  meter_state_t     state_sat;

  interval_meter #(.CLKS_PER_MS(CLKS), .CNT_W(16), .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in),
    .period_ms(period_main), .valid(valid_main), .timeout(timeout_main),
    .level(level_main), .state_dbg(state_main)
  );

  interval_meter #(.CLKS_PER_MS(CLKS), .CNT_W(SAT_W), .TIMEOUT_MS(0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in),
    .period_ms(period_sat), .valid(valid_sat), .timeout(timeout_sat),
    .level(level_sat), .state_dbg(state_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Interval model: remembers the timestamp of the last seen edge; a new edge
  // reports floor(cycles_between_edges / CLKS), clipped to the counter maximum.
  typedef struct {
    int mode;   // 0 waiting for first edge, 1 measuring, 2 stalled
    int last_n;
    int period;
    bit valid;
    bit timeout;
  } model_t;

  function automatic model_t model_step(model_t m, bit edge_seen, int n, int cnt_max, int tmo_ms);
    model_t r;
    r = m;
    r.valid = 1'b0;
    if (edge_seen) begin
      if (m.mode == 1) begin
        r.valid  = 1'b1;
        r.period = (n - m.last_n) / CLKS;
        if (r.period > cnt_max) r.period = cnt_max;
      end
      r.mode    = 1;
      r.timeout = 1'b0;
      r.last_n  = n;
    end else if (m.mode == 1 && tmo_ms != 0 && (n - m.last_n) >= tmo_ms * CLKS + 1) begin
      r.mode    = 2;
      r.timeout = 1'b1;
    end
    return r;
  endfunction

  function automatic meter_state_t mode_name(int mode);
    case (mode)
      1:       return MEASURE;
      2:       return STALL;
      default: return IDLE;
    endcase
  endfunction

  model_t   m_main;
  model_t   m_sat;
  bit [3:0] hist = '0;   // hist[k] = sig_in as sampled k clock edges ago
  int       n_clk = 0;
  bit       model_ready = 1'b0;

  // An input change sampled at edge k is reported after edge k+2.
  always @(posedge clk) begin
    if (!reset_n) begin
      hist   = '0;
      m_main = '{default: 0};
      m_sat  = '{default: 0};
    end else begin
      n_clk++;
      hist   = {hist[2:0], sig_in};
      m_main = model_step(m_main, hist[2] ^ hist[3], n_clk, 65535, TMO);
      m_sat  = model_step(m_sat,  hist[2] ^ hist[3], n_clk, (1 << SAT_W) - 1, 0);
    end
    model_ready = 1'b1;
  end

  // scoreboard: every cycle, both instances against the model
  always @(negedge clk) begin
    if (model_ready) begin
      check("main_period",  period_main,       m_main.period);
      check("main_valid",   valid_main,        m_main.valid);
      check("main_timeout", timeout_main,      m_main.timeout);
      check("main_level",   level_main,        hist[2]);
      check("main_state",   int'(state_main),  int'(mode_name(m_main.mode)));
      check("sat_period",   period_sat,        m_sat.period);
      check("sat_valid",    valid_sat,         m_sat.valid);
      check("sat_timeout",  timeout_sat,       m_sat.timeout);
      check("sat_level",    level_sat,         hist[2]);
      check("sat_state",    int'(state_sat),   int'(mode_name(m_sat.mode)));
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_after(input int gap);
    wait_clks(gap);
    sig_in = ~sig_in;
  endtask

  task automatic gen_run(input int delay_ms, input int n_toggles);
    repeat (n_toggles) toggle_after((delay_ms + 1) * CLKS);
  endtask

  int gaps[4]     = '{25, 59, 101, 7};
  int gap_exp[4]  = '{2, 5, 10, 0};

  initial begin
    reset_n = 1'b0;
    sig_in  = 1'b0;
    wait_clks(4);
    reset_n = 1'b1;

    // Reset mid-count: three edges 40 clk apart, then reset with ms_cnt at 7.
    toggle_after(3);
    toggle_after(40);
    toggle_after(40);
    wait_clks(76);
    check("pre_reset_period", period_main, 4);
    check("pre_reset_level",  level_main,  1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_period",  period_main,  0);
    check("async_reset_valid",   valid_main,   0);
    check("async_reset_timeout", timeout_main, 0);
    check("async_reset_level",   level_main,   0);
    wait_clks(3);
    reset_n = 1'b1;
    // sig_in is still high, so release itself produces the first, unmeasured edge.
    wait_clks(6);
    check("first_edge_no_update", period_main, 0);
    check("first_edge_level",     level_main,  1);

    // Steady toggling every 40 clk.
    repeat (3) toggle_after(40);
    wait_clks(5);
    check("steady_40clk", period_main, 4);

    // Generator loopback, delay_ms = 3.
    gen_run(3, 4);
    wait_clks(5);
    check("loopback_d3", period_main, 4);

    // Spacing 30: every edge lands on the tick cycle.
    repeat (3) toggle_after(30);
    wait_clks(5);
    check("coincident_tick", period_main, 3);

    // Stall, then recover.
    wait_clks(520);
    check("stall_timeout",     timeout_main, 1);
    check("stall_period_held", period_main,  3);
    check("sat_no_timeout",    timeout_sat,  0);
    sig_in = ~sig_in;
    wait_clks(5);
    check("recover_timeout",   timeout_main, 0);
    check("recover_no_update", period_main,  3);
    check("sat_after_stall",   period_sat,   15);
    toggle_after(15);
    wait_clks(5);
    check("recover_20clk", period_main, 2);

    // Saturation on the 4-bit instance.
    repeat (2) toggle_after(300);
    wait_clks(5);
    check("sat_clip_15",    period_sat,  15);
    check("main_300clk",    period_main, 30);

    // One-cycle pulse measures 0.
    toggle_after(10);
    toggle_after(1);
    wait_clks(5);
    check("pulse_zero", period_main, 0);

    // Odd spacings.
    toggle_after(10);
    wait_clks(4);
    for (int i = 0; i < 4; i++) begin
      toggle_after(gaps[i] - 4);
      wait_clks(4);
      check($sformatf("gap_%0d", gaps[i]), period_main, gap_exp[i]);
    end

    wait_clks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
